// File: rtl/sxrrisc621_tag_cam.sv
// Tag CAM for the sxrRISC621 cache: registered lookup with priority-encoded hit,
// first-invalid/round-robin victim selection, per-entry invalidate and flush.
module sxrrisc621_tag_cam #(
    parameter  int unsigned TAG_W = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lookup_valid,
    input  logic [TAG_W-1:0] lookup_tag,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             alloc_en,
    input  logic             inv_en,
    input  logic [IDX_W-1:0] inv_idx,
    input  logic             flush,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [TAG_W-1:0] rd_tag,
    output logic             rd_valid,
    output logic             hit,
    output logic [IDX_W-1:0] hit_idx,
    output logic [DEPTH-1:0] mbits,
    output logic [IDX_W-1:0] victim_idx,
    output logic             full
);

    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [DEPTH-1:0] match_c;
    logic [IDX_W-1:0] rr_q;
    logic [IDX_W-1:0] rr_d;
    logic [IDX_W-1:0] enc_c;
    logic [IDX_W-1:0] wr_sel;
    logic             wr_go;

    // Match vector against pre-edge array state, lowest index wins
    always_comb begin
        match_c = '0;
        enc_c   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            match_c[i] = valid_q[i] && (tag_q[i] == lookup_tag);
        end
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (match_c[i]) enc_c = IDX_W'(i);
        end
    end

    // Victim: lowest invalid entry, otherwise the round-robin pointer
    always_comb begin
        victim_idx = rr_q;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!valid_q[i]) victim_idx = IDX_W'(i);
        end
    end

    assign full     = &valid_q;
    assign rd_tag   = tag_q[rd_idx];
    assign rd_valid = valid_q[rd_idx];

    assign wr_go  = !flush && (wr_en || alloc_en);
    assign wr_sel = wr_en ? wr_idx : victim_idx;

    // Next valid/pointer state; invalidate is applied after the write
    always_comb begin
        valid_d = valid_q;
        rr_d    = rr_q;
        if (flush) begin
            valid_d = '0;
            rr_d    = '0;
        end else begin
            if (wr_en || alloc_en) valid_d[wr_sel] = 1'b1;
            if (!wr_en && alloc_en && full) rr_d = rr_q + IDX_W'(1);
            if (inv_en) valid_d[inv_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_q[i] <= '0;
            end
            valid_q <= '0;
            rr_q    <= '0;
            hit     <= 1'b0;
            hit_idx <= '0;
            mbits   <= '0;
        end else begin
            if (wr_go) tag_q[wr_sel] <= wr_tag;
            valid_q <= valid_d;
            rr_q    <= rr_d;
            if (lookup_valid) begin
                hit     <= |match_c;
                hit_idx <= enc_c;
                mbits   <= match_c;
            end else begin
                hit   <= 1'b0;
                mbits <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sxrrisc621_tag_cam.sv
// Scoreboard bench for sxrrisc621_tag_cam: directed plan plus random traffic
// against an array-level reference model.
module tb_sxrrisc621_tag_cam;

    localparam int unsigned TAG_W = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned IDX_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             lookup_valid;
    logic [TAG_W-1:0] lookup_tag;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             alloc_en;
    logic             inv_en;
    logic [IDX_W-1:0] inv_idx;
    logic             flush;
    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_valid;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic [DEPTH-1:0] mbits;
    logic [IDX_W-1:0] victim_idx;
    logic             full;

    sxrrisc621_tag_cam #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .lookup_valid(lookup_valid), .lookup_tag(lookup_tag),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_tag(wr_tag), .alloc_en(alloc_en),
        .inv_en(inv_en), .inv_idx(inv_idx), .flush(flush), .rd_idx(rd_idx),
        .rd_tag(rd_tag), .rd_valid(rd_valid), .hit(hit), .hit_idx(hit_idx),
        .mbits(mbits), .victim_idx(victim_idx), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             hit;
        logic [IDX_W-1:0] idx;
        logic [DEPTH-1:0] mb;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 0;

    int m_tag   [DEPTH];
    bit m_valid [DEPTH];
    int m_rr;
    int m_last_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int m_victim();
        for (int i = 0; i < int'(DEPTH); i++) if (!m_valid[i]) return i;
        return m_rr;
    endfunction

    function automatic bit m_full();
        for (int i = 0; i < int'(DEPTH); i++) if (!m_valid[i]) return 0;
        return 1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            m_tag[i]   = 0;
            m_valid[i] = 0;
        end
        m_rr       = 0;
        m_last_idx = 0;
    endtask

    // Drive one cycle from a negedge, check combinational outputs, queue the
    // expected lookup response, then advance the model past the edge.
    task automatic step(input bit lv, input int lt, input bit we, input int wi, input int wt,
                        input bit ae, input bit ie, input int ii, input bit fl, input int ri);
        exp_t e;
        int   found;
        int   v;
        bit   was_full;
        lookup_valid = lv;  lookup_tag = TAG_W'(lt);
        wr_en = we;  wr_idx = IDX_W'(wi);  wr_tag = TAG_W'(wt);
        alloc_en = ae;  inv_en = ie;  inv_idx = IDX_W'(ii);
        flush = fl;  rd_idx = IDX_W'(ri);
        #1;
        chk("victim_idx", 32'(victim_idx), 32'(m_victim()));
        chk("full", 32'(full), 32'(m_full()));
        chk("rd_tag", 32'(rd_tag), 32'(m_tag[ri]));
        chk("rd_valid", 32'(rd_valid), 32'(m_valid[ri]));

        e.hit = 1'b0;
        e.mb  = '0;
        e.idx = IDX_W'(m_last_idx);
        if (lv) begin
            found = -1;
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (m_valid[i] && m_tag[i] == lt) begin
                    e.mb[i] = 1'b1;
                    if (found < 0) found = i;
                end
            end
            e.hit      = (found >= 0);
            m_last_idx = (found >= 0) ? found : 0;
            e.idx      = IDX_W'(m_last_idx);
        end
        exp_q.push_back(e);

        was_full = m_full();
        v        = m_victim();
        if (fl) begin
            for (int i = 0; i < int'(DEPTH); i++) m_valid[i] = 0;
            m_rr = 0;
        end else begin
            if (we) begin
                m_tag[wi]   = wt;
                m_valid[wi] = 1;
            end else if (ae) begin
                m_tag[v]   = wt;
                m_valid[v] = 1;
                if (was_full) m_rr = (m_rr + 1) % int'(DEPTH);
            end
            if (ie) m_valid[ii] = 0;
        end
        @(negedge clk);
    endtask

    // Monitor: each edge presents one lookup result slot
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (mon_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("hit", 32'(hit), 32'(e.hit));
            chk("hit_idx", 32'(hit_idx), 32'(e.idx));
            chk("mbits", 32'(mbits), 32'(e.mb));
        end
    end

    initial begin
        rst_n = 1'b0;
        lookup_valid = 0; lookup_tag = '0; wr_en = 0; wr_idx = '0; wr_tag = '0;
        alloc_en = 0; inv_en = 0; inv_idx = '0; flush = 0; rd_idx = '0;
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_hit", 32'(hit), 32'd0);
        chk("reset_mbits", 32'(mbits), 32'd0);
        chk("reset_hit_idx", 32'(hit_idx), 32'd0);
        chk("reset_victim", 32'(victim_idx), 32'd0);
        chk("reset_full", 32'(full), 32'd0);
        @(negedge clk);
        mon_en = 1;

        // Lookup of tag 0 after reset must miss
        step(1, 'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        // Fill with four allocations, then lookup 0x33 -> idx 2
        step(0, 0, 0, 0, 'h11, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 'h22, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 'h33, 1, 0, 0, 0, 2);
        step(0, 0, 0, 0, 'h44, 1, 0, 0, 0, 3);
        chk("plan_full", 32'(full), 32'd1);
        step(1, 'h33, 0, 0, 0, 0, 0, 0, 0, 0);
        // Round-robin replacement with wrap
        step(0, 0, 0, 0, 'h55, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 'h66, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 'h77, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 'h88, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 'h99, 1, 0, 0, 0, 0);
        chk("plan_rr_wrap_tag0", 32'(rd_tag), 32'h99);
        step(1, 'h11, 0, 0, 0, 0, 0, 0, 0, 1);
        // Same-cycle write is invisible to the lookup; duplicates resolve low
        step(1, 'hAA, 1, 1, 'hAA, 0, 0, 0, 0, 1);
        step(1, 'hAA, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 3, 'hAA, 0, 0, 0, 0, 3);
        step(1, 'hAA, 0, 0, 0, 0, 0, 0, 0, 3);
        chk("plan_dup_mbits", 32'(mbits), 32'b1010);
        // Write and invalidate the same index
        step(0, 0, 1, 2, 'hBB, 0, 1, 2, 0, 2);
        chk("plan_inv_rd_valid", 32'(rd_valid), 32'd0);
        chk("plan_inv_rd_tag", 32'(rd_tag), 32'hBB);
        chk("plan_inv_victim", 32'(victim_idx), 32'd2);
        // Flush wins over allocation
        step(0, 0, 0, 0, 'hCC, 1, 0, 0, 1, 2);
        step(1, 'hAA, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic over a small tag alphabet to produce hits and duplicates
        for (int n = 0; n < 500; n++) begin
            step($urandom_range(0, 1), $urandom_range(0, 5), ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 3), $urandom_range(0, 5), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 4) == 0), $urandom_range(0, 3),
                 ($urandom_range(0, 40) == 0), $urandom_range(0, 3));
        end

        // Guarantee a nonzero held hit_idx before the mid-lookup reset
        step(0, 0, 1, 3, 'hEE, 0, 0, 0, 0, 0);
        step(1, 'hEE, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);

        // Reset pulsed between lookup request and the next edge
        mon_en = 0;
        lookup_valid = 1'b1; lookup_tag = 8'hEE;
        #1 rst_n = 1'b0;
        #1 lookup_valid = 1'b0;
        #1 rst_n = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
        chk("midreset_hit", 32'(hit), 32'd0);
        chk("midreset_mbits", 32'(mbits), 32'd0);
        chk("midreset_hit_idx", 32'(hit_idx), 32'd0);
        chk("midreset_full", 32'(full), 32'd0);
        chk("midreset_victim", 32'(victim_idx), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
